clk_div_switch: RTL

CLK_DIV_SWITCH -- requirements
Module: clk_div_switch

---
 rtl/clk_div_switch.sv | 66 ++++++
 1 files changed

// File: rtl/clk_div_switch.sv
// clk_div_switch: glitch-free switchable clock divider.
// A channel switch is applied only at a period boundary (end of the low phase).
module clk_div_switch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*CNT_W-1:0] div_cfg,
  output logic                    clk_out,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    busy,
  output logic                    sw_done,
  output logic                    running
);
  typedef enum logic [1:0] {STOP, RUN_HI, RUN_LO} state_t;
  state_t r_state, w_nxt;
  logic [SEL_W-1:0] r_sel_q, r_cur_sel, w_new_sel;
  logic [CNT_W-1:0] r_cnt, r_ract, w_new_raw, w_new_r, w_r0_raw, w_r0;
  logic r_clk_out, r_sw_done, w_busy, w_end, w_load, w_sel_ok;
  assign w_busy    = r_sel_q != r_cur_sel;
  assign w_end     = r_cnt == r_ract - 1'b1;
  assign w_sel_ok  = 32'(sel) < 32'(NUM_CH);
  assign w_new_sel = w_busy ? r_sel_q : r_cur_sel;
  assign w_new_raw = div_cfg[int'(w_new_sel)*CNT_W +: CNT_W];
  assign w_new_r   = (w_new_raw == '0) ? CNT_W'(1) : w_new_raw;
  assign w_r0_raw  = div_cfg[0 +: CNT_W];
  assign w_r0      = (w_r0_raw == '0) ? CNT_W'(1) : w_r0_raw;
  // Ratio and channel are latched only when a high phase begins.
  assign w_load    = (w_nxt == RUN_HI) && (r_state != RUN_HI);
  always_ff @(posedge clk)
    if (rst) r_state <= STOP;
    else     r_state <= w_nxt;
  always_comb
    w_nxt = (r_state == STOP)   ? (en ? RUN_HI : STOP) :
            (r_state == RUN_HI) ? (w_end ? RUN_LO : RUN_HI) :
            (w_end ? (en ? RUN_HI : STOP) : RUN_LO);
  always_comb begin
    clk_out = r_clk_out;
    cur_sel = r_cur_sel;
    busy    = w_busy;
    sw_done = r_sw_done;
    running = r_state != STOP;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt     <= '0;
      r_ract    <= w_r0;
      r_cur_sel <= '0;
      r_sel_q   <= '0;
      r_clk_out <= 1'b0;
      r_sw_done <= 1'b0;
    end else begin
      r_cnt     <= (w_nxt != r_state || r_state == STOP) ? '0 : r_cnt + 1'b1;
      r_clk_out <= w_nxt == RUN_HI;
      r_sw_done <= w_load && w_busy;
      if (w_sel_ok) r_sel_q <= sel;
      if (w_load) begin
        r_cur_sel <= w_new_sel;
        r_ract    <= w_new_r;
      end
    end
endmodule
